pwm_ramp_ctrl: RTL and testbench

Sequencing controller for the 8-bit PWM generator. Accepts a ramp command (period width, target compare, step, dwell) over a valid/ready handshake and drives the generator's width/cmp buses. Walks cmp from its current value toward the target, one step every dwell PWM periods, then signals completion. Sits between the host register interface and the PWM generator instance.

---
 rtl/pwm_ramp_ctrl.sv | 113 +++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// Ramp sequencer for the 8-bit PWM generator: accepts a ramp command and
// walks cmp toward the target, one step every dwell PWM periods.
module pwm_ramp_ctrl (
  input  logic       clk,
  input  logic       res,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_width,
  input  logic [7:0] cfg_target,
  input  logic [7:0] cfg_step,
  input  logic [7:0] cfg_dwell,
  input  logic       abort,
  output logic [7:0] width,
  output logic [7:0] cmp,
  output logic       period_tick,
  output logic       busy,
  output logic       done
);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t     state;
  logic [8:0] pcnt;
  logic [7:0] tgt;
  logic [7:0] stp;
  logic [7:0] dwell;
  logic [7:0] dcnt;

  logic [8:0] plast;
  logic [7:0] dwell_eff;
  logic       upd;
  logic [8:0] up_sum;
  logic [8:0] dn_sum;
  logic [7:0] next_cmp;
  logic       fin;

  assign plast       = {1'b0, width} + 9'd1;
  assign period_tick = (pcnt == plast);
  assign busy        = (state == RAMP);
  assign cfg_ready   = (state == IDLE);

  assign dwell_eff = (dwell == 8'd0) ? 8'd1 : dwell;
  assign upd = (state == RAMP) && period_tick &&
               (({1'b0, dcnt} + 9'd1) == {1'b0, dwell_eff});

  // 9-bit sums so a step can never wrap past 0 or 255
  assign up_sum = {1'b0, cmp} + {1'b0, stp};
  assign dn_sum = {1'b0, cmp} - {1'b0, stp};

  always_comb begin
    next_cmp = cmp;
    if (tgt > cmp) begin
      if (up_sum > {1'b0, tgt}) next_cmp = tgt;
      else                      next_cmp = up_sum[7:0];
    end else if (tgt < cmp) begin
      if (dn_sum[8] || (dn_sum[7:0] < tgt)) next_cmp = tgt;
      else                                  next_cmp = dn_sum[7:0];
    end
  end

  assign fin = (next_cmp == tgt);

  always_ff @(posedge clk) begin
    if (res) begin
      state <= IDLE;
      width <= 8'd0;
      cmp   <= 8'd0;
      done  <= 1'b0;
      pcnt  <= 9'd0;
      dcnt  <= 8'd0;
      tgt   <= 8'd0;
      stp   <= 8'd0;
      dwell <= 8'd0;
    end else begin
      done <= 1'b0;
      pcnt <= period_tick ? 9'd0 : pcnt + 9'd1;
      unique case (state)
        IDLE: begin
          if (cfg_valid) begin
            width <= cfg_width;
            tgt   <= cfg_target;
            stp   <= cfg_step;
            dwell <= cfg_dwell;
            pcnt  <= 9'd0;
            dcnt  <= 8'd0;
            if ((cfg_step == 8'd0) || (cmp == cfg_target))
              done <= 1'b1;
            else
              state <= RAMP;
          end
        end
        RAMP: begin
          // a final update beats a coincident abort
          if (upd && fin) begin
            cmp   <= next_cmp;
            dcnt  <= 8'd0;
            done  <= 1'b1;
            state <= IDLE;
          end else if (abort) begin
            state <= IDLE;
          end else if (upd) begin
            cmp  <= next_cmp;
            dcnt <= 8'd0;
          end else if (period_tick) begin
            dcnt <= dcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: vector table of ramp checkpoints
// plus hand sequences for abort, reset, handshake and back-to-back.
module tb_pwm_ramp_ctrl;

  logic       clk = 1'b0;
  logic       res;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_width;
  logic [7:0] cfg_target;
  logic [7:0] cfg_step;
  logic [7:0] cfg_dwell;
  logic       abort;
  logic [7:0] width;
  logic [7:0] cmp;
  logic       period_tick;
  logic       busy;
  logic       done;

  pwm_ramp_ctrl dut (
    .clk        (clk),
    .res        (res),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_width  (cfg_width),
    .cfg_target (cfg_target),
    .cfg_step   (cfg_step),
    .cfg_dwell  (cfg_dwell),
    .abort      (abort),
    .width      (width),
    .cmp        (cmp),
    .period_tick(period_tick),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         go;
    logic [7:0] w, t, s, d;
    int         cyc;
    logic [7:0] ecmp, ewid;
    logic       ebusy, edone, etick;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;
  int now = 0;

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step_to(int n);
    while (now < n) begin
      @(negedge clk);
      now++;
    end
  endtask

  task automatic issue(logic [7:0] w, logic [7:0] t,
                       logic [7:0] s, logic [7:0] d);
    cfg_valid  = 1'b1;
    cfg_width  = w;
    cfg_target = t;
    cfg_step   = s;
    cfg_dwell  = d;
    @(negedge clk);
    cfg_valid = 1'b0;
    now = 0;
  endtask

  task automatic add(bit go, int w, int t, int s, int d, int cyc,
                     int ecmp, int ewid, bit eb, bit ed, bit et);
    vec_t v;
    v.go = go;
    v.w = 8'(w); v.t = 8'(t); v.s = 8'(s); v.d = 8'(d);
    v.cyc = cyc;
    v.ecmp = 8'(ecmp); v.ewid = 8'(ewid);
    v.ebusy = eb; v.edone = ed; v.etick = et;
    vq.push_back(v);
  endtask

  initial begin
    // up ramp 0 -> 50, period 12
    add(1, 10, 50, 20, 1,  0,  0, 10, 1, 0, 0);
    add(0,  0,  0,  0, 0, 11,  0, 10, 1, 0, 1);
    add(0,  0,  0,  0, 0, 12, 20, 10, 1, 0, 0);
    add(0,  0,  0,  0, 0, 23, 20, 10, 1, 0, 1);
    add(0,  0,  0,  0, 0, 24, 40, 10, 1, 0, 0);
    add(0,  0,  0,  0, 0, 35, 40, 10, 1, 0, 1);
    add(0,  0,  0,  0, 0, 36, 50, 10, 0, 1, 0);
    add(0,  0,  0,  0, 0, 37, 50, 10, 0, 0, 0);
    // down ramp 50 -> 5, dwell 3, period 6
    add(1,  4,  5, 20, 3,  0, 50,  4, 1, 0, 0);
    add(0,  0,  0,  0, 0, 17, 50,  4, 1, 0, 1);
    add(0,  0,  0,  0, 0, 18, 30,  4, 1, 0, 0);
    add(0,  0,  0,  0, 0, 35, 30,  4, 1, 0, 1);
    add(0,  0,  0,  0, 0, 36, 10,  4, 1, 0, 0);
    add(0,  0,  0,  0, 0, 54,  5,  4, 0, 1, 0);
    add(0,  0,  0,  0, 0, 55,  5,  4, 0, 0, 0);
    // step == 0
    add(1,  6,100,  0, 1,  0,  5,  6, 0, 1, 0);
    add(0,  0,  0,  0, 0,  1,  5,  6, 0, 0, 0);
    // target == cmp
    add(1,  3,  5,  9, 2,  0,  5,  3, 0, 1, 0);
    add(0,  0,  0,  0, 0,  1,  5,  3, 0, 0, 0);
    // dwell 0 acts as 1
    add(1,  2,  9,  4, 0,  0,  5,  2, 1, 0, 0);
    add(0,  0,  0,  0, 0,  3,  5,  2, 1, 0, 1);
    add(0,  0,  0,  0, 0,  4,  9,  2, 0, 1, 0);
    add(0,  0,  0,  0, 0,  5,  9,  2, 0, 0, 0);
    // 9 - 200 clamps at target 0
    add(1,  0,  0,200, 1,  0,  9,  0, 1, 0, 0);
    add(0,  0,  0,  0, 0,  1,  9,  0, 1, 0, 1);
    add(0,  0,  0,  0, 0,  2,  0,  0, 0, 1, 0);
    // 200 + 200 clamps at target 255
    add(1,  0,255,200, 1,  0,  0,  0, 1, 0, 0);
    add(0,  0,  0,  0, 0,  2,200,  0, 1, 0, 0);
    add(0,  0,  0,  0, 0,  4,255,  0, 0, 1, 0);

    res = 1'b1; cfg_valid = 1'b0; abort = 1'b0;
    cfg_width = 0; cfg_target = 0; cfg_step = 0; cfg_dwell = 0;
    repeat (3) @(negedge clk);
    res = 1'b0;
    chk("rst width", width, 8'd0);
    chk("rst cmp", cmp, 8'd0);
    chk("rst busy", 8'(busy), 8'd0);
    chk("rst ready", 8'(cfg_ready), 8'd1);
    chk("rst done", 8'(done), 8'd0);

    foreach (vq[i]) begin
      if (vq[i].go) issue(vq[i].w, vq[i].t, vq[i].s, vq[i].d);
      step_to(vq[i].cyc);
      chk($sformatf("v%0d cmp", i), cmp, vq[i].ecmp);
      chk($sformatf("v%0d width", i), width, vq[i].ewid);
      chk($sformatf("v%0d busy", i), 8'(busy), 8'(vq[i].ebusy));
      chk($sformatf("v%0d done", i), 8'(done), 8'(vq[i].edone));
      chk($sformatf("v%0d tick", i), 8'(period_tick), 8'(vq[i].etick));
    end

    res = 1'b1;
    @(negedge clk);
    res = 1'b0;

    // cfg_valid held in RAMP with other fields, then abort after first update
    issue(10, 50, 20, 1);
    cfg_valid = 1'b1;
    cfg_width = 99; cfg_target = 7; cfg_step = 1; cfg_dwell = 5;
    step_to(5);
    chk("hs ready", 8'(cfg_ready), 8'd0);
    chk("hs width", width, 8'd10);
    step_to(12);
    chk("hs cmp", cmp, 8'd20);
    step_to(13);
    cfg_valid = 1'b0;
    step_to(15);
    abort = 1'b1;
    step_to(16);
    abort = 1'b0;
    chk("abort busy", 8'(busy), 8'd0);
    chk("abort ready", 8'(cfg_ready), 8'd1);
    chk("abort cmp", cmp, 8'd20);
    chk("abort done", 8'(done), 8'd0);
    chk("abort width", width, 8'd10);
    step_to(17);
    chk("abort done2", 8'(done), 8'd0);
    chk("abort cmp2", cmp, 8'd20);

    // reset mid-ramp at cmp=40
    issue(10, 100, 20, 1);
    step_to(12);
    chk("pre-rst cmp", cmp, 8'd40);
    res = 1'b1;
    step_to(13);
    res = 1'b0;
    chk("midrst width", width, 8'd0);
    chk("midrst cmp", cmp, 8'd0);
    chk("midrst busy", 8'(busy), 8'd0);
    chk("midrst ready", 8'(cfg_ready), 8'd1);
    chk("midrst done", 8'(done), 8'd0);

    // abort with cfg_valid in IDLE is ignored
    abort = 1'b1;
    issue(2, 8, 8, 1);
    abort = 1'b0;
    chk("idle-abort busy", 8'(busy), 8'd1);
    chk("idle-abort width", width, 8'd2);
    step_to(4);
    chk("idle-abort cmp", cmp, 8'd8);
    chk("idle-abort done", 8'(done), 8'd1);

    // new command the cycle after done
    step_to(5);
    issue(1, 0, 8, 1);
    chk("b2b busy", 8'(busy), 8'd1);
    chk("b2b width", width, 8'd1);
    chk("b2b cmp", cmp, 8'd8);
    step_to(3);
    chk("b2b cmp2", cmp, 8'd0);
    chk("b2b done", 8'(done), 8'd1);

    // abort coinciding with the final update
    issue(0, 4, 4, 1);
    step_to(1);
    chk("fin tick", 8'(period_tick), 8'd1);
    abort = 1'b1;
    step_to(2);
    abort = 1'b0;
    chk("fin cmp", cmp, 8'd4);
    chk("fin done", 8'(done), 8'd1);
    chk("fin busy", 8'(busy), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
